// File: rtl/ppl_hazard_sb.sv
// ppl_hazard_sb
// Hazard, forwarding and multi-cycle scoreboard unit that sits beside decode.
//
// Ports
//   clock, resetn              clock, asynchronous active-low reset
//   dValid, rs, rt             decode slot valid and its source registers
//   useRs, useRt               decode instruction really reads rs / rt
//   dWreg, dDest, dIsMd        decode writes a register / its destination /
//                              it is a multi-cycle op
//   flush                      kill the decode instruction (redirect)
//   exReg, exWriteReg,         EX destination, write enable, is-load
//   exMem2Reg
//   mReg, mWriteReg, mMem2Reg  MEM destination, write enable, is-load
//   cntClr                     synchronous clear of stallCnt
//   pcContinue                 1 = pipeline advances, 0 = hold IF/ID, bubble EX
//   issue                      decode instruction accepted this cycle
//   fwdA, fwdB                 00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load
//   mdBusy, mdDest, mdWb       outstanding multi-cycle op, its destination,
//                              writeback pulse
//   stallCnt                   saturating count of stalled decode cycles

module ppl_hazard_sb #(
    parameter int AW     = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             dValid,
    input  logic [AW-1:0]    rs,
    input  logic [AW-1:0]    rt,
    input  logic             useRs,
    input  logic             useRt,
    input  logic             dWreg,
    input  logic [AW-1:0]    dDest,
    input  logic             dIsMd,
    input  logic             flush,
    input  logic [AW-1:0]    exReg,
    input  logic [AW-1:0]    mReg,
    input  logic             exWriteReg,
    input  logic             mWriteReg,
    input  logic             exMem2Reg,
    input  logic             mMem2Reg,
    input  logic             cntClr,
    output logic             pcContinue,
    output logic             issue,
    output logic [1:0]       fwdA,
    output logic [1:0]       fwdB,
    output logic             mdBusy,
    output logic [AW-1:0]    mdDest,
    output logic             mdWb,
    output logic [CNT_W-1:0] stallCnt
);

    localparam int CW = $clog2(MD_LAT + 1);

    logic [CW-1:0] md_cnt;
    logic          ex_hit_a, ex_hit_b, m_hit_a, m_hit_b;
    logic          load_use, md_raw, md_waw, md_struct;
    logic          stall;

    // A writer to r0 never produces a forwardable value.
    assign ex_hit_a = exWriteReg && (exReg != '0) && (exReg == rs);
    assign ex_hit_b = exWriteReg && (exReg != '0) && (exReg == rt);
    assign m_hit_a  = mWriteReg  && (mReg  != '0) && (mReg  == rs);
    assign m_hit_b  = mWriteReg  && (mReg  != '0) && (mReg  == rt);

    // A load in EX cannot forward yet, so it drops through to the MEM match.
    always_comb begin
        fwdA = 2'b00;
        if (ex_hit_a && !exMem2Reg)     fwdA = 2'b01;
        else if (m_hit_a && !mMem2Reg)  fwdA = 2'b10;
        else if (m_hit_a)               fwdA = 2'b11;

        fwdB = 2'b00;
        if (ex_hit_b && !exMem2Reg)     fwdB = 2'b01;
        else if (m_hit_b && !mMem2Reg)  fwdB = 2'b10;
        else if (m_hit_b)               fwdB = 2'b11;
    end

    assign load_use  = exWriteReg && exMem2Reg && (exReg != '0) &&
                       ((useRs && (exReg == rs)) || (useRt && (exReg == rt)));
    assign md_raw    = mdBusy && (mdDest != '0) &&
                       ((useRs && (rs == mdDest)) || (useRt && (rt == mdDest)));
    assign md_waw    = mdBusy && dWreg && (dDest != '0) && (dDest == mdDest);
    assign md_struct = mdBusy && dIsMd;

    // flush is deliberately kept out of the stall term.
    assign stall      = dValid && (load_use || md_raw || md_waw || md_struct);
    assign pcContinue = !stall;
    assign issue      = dValid && pcContinue && !flush;

    assign mdBusy = (md_cnt != '0);
    assign mdWb   = (md_cnt == CW'(1));

    // Countdown scoreboard: a new op can only be issued once md_cnt is zero,
    // so the load never collides with a live count.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            md_cnt <= '0;
            mdDest <= '0;
        end else if (issue && dIsMd) begin
            md_cnt <= CW'(MD_LAT);
            mdDest <= dDest;
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stallCnt <= '0;
        end else if (cntClr) begin
            stallCnt <= '0;
        end else if (stall && (stallCnt != {CNT_W{1'b1}})) begin
            stallCnt <= stallCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ppl_hazard_sb.sv
// Directed bench for ppl_hazard_sb with MD_LAT=4 and a 3-bit stall counter.
// Inputs change 1 ns after the rising edge; outputs are checked 2 ns after it.

module tb_ppl_hazard_sb;

    localparam int AW     = 5;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 3;

    logic             clock = 1'b0;
    logic             resetn;
    logic             dValid, useRs, useRt, dWreg, dIsMd, flush;
    logic [AW-1:0]    rs, rt, dDest, exReg, mReg;
    logic             exWriteReg, mWriteReg, exMem2Reg, mMem2Reg, cntClr;
    logic             pcContinue, issue, mdBusy, mdWb;
    logic [1:0]       fwdA, fwdB;
    logic [AW-1:0]    mdDest;
    logic [CNT_W-1:0] stallCnt;

    int n_tests = 0;
    int n_fail  = 0;

    ppl_hazard_sb #(.AW(AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .dValid     (dValid),
        .rs         (rs),
        .rt         (rt),
        .useRs      (useRs),
        .useRt      (useRt),
        .dWreg      (dWreg),
        .dDest      (dDest),
        .dIsMd      (dIsMd),
        .flush      (flush),
        .exReg      (exReg),
        .mReg       (mReg),
        .exWriteReg (exWriteReg),
        .mWriteReg  (mWriteReg),
        .exMem2Reg  (exMem2Reg),
        .mMem2Reg   (mMem2Reg),
        .cntClr     (cntClr),
        .pcContinue (pcContinue),
        .issue      (issue),
        .fwdA       (fwdA),
        .fwdB       (fwdB),
        .mdBusy     (mdBusy),
        .mdDest     (mdDest),
        .mdWb       (mdWb),
        .stallCnt   (stallCnt)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        dValid = 0; useRs = 0; useRt = 0; dWreg = 0; dIsMd = 0; flush = 0;
        rs = '0; rt = '0; dDest = '0; exReg = '0; mReg = '0;
        exWriteReg = 0; mWriteReg = 0; exMem2Reg = 0; mMem2Reg = 0; cntClr = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clr_cnt();
        idle();
        cntClr = 1;
        tick();
        cntClr = 0;
    endtask

    task automatic drive_mult(input logic [AW-1:0] dst);
        idle();
        dValid = 1; dIsMd = 1; dWreg = 1; dDest = dst;
    endtask

    initial begin
        idle();
        resetn = 0;
        dValid = 1;
        #3;
        chk("rst_mdBusy", 32'(mdBusy), 0);
        chk("rst_mdWb", 32'(mdWb), 0);
        chk("rst_pcContinue", 32'(pcContinue), 1);
        chk("rst_issue", 32'(issue), 1);
        chk("rst_stallCnt", 32'(stallCnt), 0);
        chk("rst_mdDest", 32'(mdDest), 0);
        #4 resetn = 1;
        tick();

        // Forwarding priority
        idle();
        exReg = 3; mReg = 3; rs = 3; rt = 3; exWriteReg = 1; mWriteReg = 1;
        settle();
        chk("fwdA_ex", 32'(fwdA), 1);
        chk("fwdB_ex", 32'(fwdB), 1);
        exReg = 4; settle();
        chk("fwdA_mem_alu", 32'(fwdA), 2);
        mMem2Reg = 1; settle();
        chk("fwdA_mem_load", 32'(fwdA), 3);
        rs = 0; settle();
        chk("fwdA_none", 32'(fwdA), 0);
        exReg = 0; mReg = 0; settle();
        chk("fwdA_r0", 32'(fwdA), 0);
        exReg = 3; rs = 3; exMem2Reg = 1; mReg = 0; settle();
        chk("fwdA_ex_load_no_fwd", 32'(fwdA), 0);

        // Load-use: one stall, then load data from MEM
        clr_cnt();
        exReg = 5; exWriteReg = 1; exMem2Reg = 1;
        dValid = 1; rs = 1; useRs = 1; rt = 5; useRt = 1; dWreg = 1; dDest = 6;
        settle();
        chk("lu_pcContinue", 32'(pcContinue), 0);
        chk("lu_issue", 32'(issue), 0);
        tick();
        exReg = 0; exWriteReg = 0; exMem2Reg = 0;
        mReg = 5; mWriteReg = 1; mMem2Reg = 1;
        settle();
        chk("lu_stallCnt", 32'(stallCnt), 1);
        chk("lu_pc_after", 32'(pcContinue), 1);
        chk("lu_fwdB", 32'(fwdB), 3);
        chk("lu_issue_after", 32'(issue), 1);
        tick();
        idle();
        exReg = 5; exWriteReg = 1; exMem2Reg = 1;
        dValid = 1; rt = 5; useRt = 0;
        settle();
        chk("lu_unused_rt", 32'(pcContinue), 1);
        tick();
        chk("lu_unused_cnt", 32'(stallCnt), 1);

        // Multi-cycle RAW
        clr_cnt();
        drive_mult(8);
        settle();
        chk("md_issue", 32'(issue), 1);
        chk("md_busy_c0", 32'(mdBusy), 0);
        tick();
        for (int c = 1; c <= MD_LAT; c++) begin
            idle();
            dValid = 1; rs = 8; useRs = 1; dWreg = 1; dDest = 10;
            settle();
            chk($sformatf("raw_busy_c%0d", c), 32'(mdBusy), 1);
            chk($sformatf("raw_pc_c%0d", c), 32'(pcContinue), 0);
            chk($sformatf("raw_wb_c%0d", c), 32'(mdWb), (c == MD_LAT) ? 1 : 0);
            tick();
        end
        settle();
        chk("raw_busy_c5", 32'(mdBusy), 0);
        chk("raw_issue_c5", 32'(issue), 1);
        chk("raw_stallCnt", 32'(stallCnt), 4);
        chk("raw_mdDest", 32'(mdDest), 8);
        idle();
        tick();

        // Structural and WAW
        clr_cnt();
        drive_mult(8);
        tick();
        idle();
        tick();
        for (int c = 2; c <= MD_LAT; c++) begin
            drive_mult(12);
            settle();
            chk($sformatf("struct_pc_c%0d", c), 32'(pcContinue), 0);
            tick();
        end
        drive_mult(12);
        settle();
        chk("struct_issue_c5", 32'(issue), 1);
        tick();
        idle();
        dValid = 1; dWreg = 1; dDest = 12;
        settle();
        chk("struct_mdDest", 32'(mdDest), 12);
        chk("waw_pc", 32'(pcContinue), 0);
        dDest = 9; settle();
        chk("waw_other_issue", 32'(issue), 1);
        idle();
        for (int c = 0; c < MD_LAT; c++) tick();
        chk("struct_drained", 32'(mdBusy), 0);
        chk("struct_stallCnt", 32'(stallCnt), 3);

        // Multi-cycle op writing r0
        clr_cnt();
        drive_mult(0);
        tick();
        idle();
        dValid = 1; rs = 0; rt = 0; useRs = 1; useRt = 1; dWreg = 1; dDest = 0;
        settle();
        chk("r0_busy", 32'(mdBusy), 1);
        chk("r0_no_raw", 32'(pcContinue), 1);
        dIsMd = 1; settle();
        chk("r0_struct", 32'(pcContinue), 0);
        idle();
        for (int c = 0; c < MD_LAT; c++) tick();

        // Flushed multi-cycle op never starts
        drive_mult(8);
        flush = 1;
        settle();
        chk("flush_issue", 32'(issue), 0);
        chk("flush_pc", 32'(pcContinue), 1);
        tick();
        idle();
        settle();
        chk("flush_busy", 32'(mdBusy), 0);

        // Counter saturation and clear priority
        clr_cnt();
        exReg = 5; exWriteReg = 1; exMem2Reg = 1;
        dValid = 1; rs = 5; useRs = 1;
        for (int c = 0; c < 10; c++) tick();
        chk("cnt_saturate", 32'(stallCnt), 7);
        cntClr = 1;
        tick();
        chk("cnt_clr_wins", 32'(stallCnt), 0);
        cntClr = 0;
        tick();
        chk("cnt_restart", 32'(stallCnt), 1);

        // Reset in the middle of a multi-cycle op
        clr_cnt();
        drive_mult(8);
        tick();
        idle();
        dValid = 1; rs = 8; useRs = 1;
        tick();
        chk("mr_pre_cnt", 32'(stallCnt), 1);
        #2 resetn = 0;
        #1;
        chk("mr_busy", 32'(mdBusy), 0);
        chk("mr_cnt", 32'(stallCnt), 0);
        chk("mr_wb", 32'(mdWb), 0);
        tick();
        chk("mr_wb_held", 32'(mdWb), 0);
        #3 resetn = 1;
        settle();
        chk("mr_pc_release", 32'(pcContinue), 1);
        chk("mr_issue_release", 32'(issue), 1);
        idle();
        for (int c = 0; c < MD_LAT; c++) begin
            tick();
            chk($sformatf("mr_no_wb_%0d", c), 32'(mdWb), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ppl_hazard_sb.md
# ppl_hazard_sb

Parametrised hazard, forwarding and scoreboard unit for the five-stage pipeline. It keeps the EX/MEM forwarding selects and the load-use interlock. It also tracks one outstanding long-latency multiply/divide result with a countdown scoreboard and stalls RAW, WAW and structural conflicts against it. It sits beside the decode stage, drives the fetch/decode stall and forwarding muxes, and keeps a saturating stall-cycle counter.

## Interface
- AW, 5, register address width
- MD_LAT, 4, multi-cycle unit latency in cycles; legal values are 2 and above
- CNT_W, 32, stall counter width
- clock  in  1  single clock; all state updates on the rising edge
- resetn  in  1  reset, asynchronous and active-low
- dValid  in  1  decode slot holds a valid instruction
- rs, rt  in  AW  decode source registers
- useRs, useRt  in  1  instruction actually reads rs / rt
- dWreg  in  1  decode instruction writes a register
- dDest  in  AW  decode destination
- dIsMd  in  1  decode instruction is a multi-cycle op
- flush  in  1  kill the decode instruction; branch/jump redirect
- exReg, mReg  in  AW  EX / MEM destination
- exWriteReg, mWriteReg  in  1  EX / MEM write enable
- exMem2Reg, mMem2Reg  in  1  EX / MEM instruction is a load
- cntClr  in  1  synchronous clear of stallCnt
- pcContinue  out  1  1 = pipeline advances; 0 = hold PC and the IF/ID register, bubble into EX
- issue  out  1  decode instruction accepted this cycle
- fwdA, fwdB  out  2  forwarding select: 00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load data
- mdBusy  out  1  multi-cycle result outstanding
- mdDest  out  AW  destination of the outstanding multi-cycle op
- mdWb  out  1  one-cycle pulse in the multi-cycle writeback cycle
- stallCnt  out  CNT_W  stall cycles since reset or the last clear

## Operation
- Forwarding is combinational and computed separately for rs→fwdA and rt→fwdB. Priority order:
  - 01 when exReg≠0, exWriteReg, exReg matches the source and ~exMem2Reg.
  - else 10 when the same match holds on MEM with ~mMem2Reg.
  - else 11 when the match holds on MEM with mMem2Reg.
  - else 00.
- Forwarding is computed regardless of useRs/useRt.
- Stall sources are combinational; any one of them forces pcContinue=0.
  - loadUse: exReg≠0, exWriteReg, exMem2Reg, and (useRs with exReg==rs or useRt with exReg==rt).
  - mdRaw: mdBusy, mdDest≠0, and a used source equals mdDest.
  - mdWaw: mdBusy, dWreg, dDest≠0 and dDest==mdDest.
  - mdStruct: mdBusy and dIsMd.
- Stall sources are evaluated only when dValid=1. With dValid=0, pcContinue=1.
- issue = dValid & pcContinue & ~flush. flush does not mask the stall; a stalled instruction is also not issued.
- Scoreboard state: mdCnt, width $clog2(MD_LAT+1), and a mdDest register.
  - On an issue edge with dIsMd: mdCnt←MD_LAT and mdDest←dDest.
  - Otherwise, when mdCnt≠0, mdCnt decrements.
  - mdBusy = (mdCnt≠0). mdWb = (mdCnt==1).
  - A multi-cycle op with dDest=0 still occupies the unit, so mdStruct applies, but it never causes RAW or WAW.
- New-op timing: a new multi-cycle op cannot be accepted while mdBusy. It is accepted no earlier than the cycle after mdWb.
- stallCnt increments on every edge where dValid & ~pcContinue. It saturates at all-ones. cntClr clears it and takes precedence over the increment.

## Timing
- Reset state: mdCnt=0, mdDest=0 and stallCnt=0. The outputs follow: mdBusy=0, mdWb=0, pcContinue=1, and issue equal to dValid & ~flush.
- Assertion of resetn is asynchronous and aborts any outstanding multi-cycle op with no mdWb pulse.
- Multi-cycle op accepted at the edge closing cycle t:
  - mdBusy is high in cycles t+1 through t+MD_LAT.
  - mdWb is high in cycle t+MD_LAT.
  - mdBusy is low from cycle t+MD_LAT+1.
- A dependent instruction in decode during cycles t+1 through t+MD_LAT stalls. It issues in cycle t+MD_LAT+1, when the regfile already holds the result.
- Load-use costs exactly one stall cycle. In the next cycle the load is in MEM and the select is 11.
- Forwarding and stall outputs have zero-cycle latency from their inputs. There is no combinational path from flush to pcContinue.

## Test plan
- Forwarding priority: exReg=mReg=rs=3, both writing, both non-load → fwdA=01. Change to exReg=4 → fwdA=10. Then set mMem2Reg=1 → fwdA=11. With rs=0 → fwdA=00.
- Load-use: lw to r5 in EX, decode add with rt=5 and useRt=1 → one cycle of pcContinue=0 and stallCnt=1, then pcContinue=1 with fwdB=11. Repeat with useRt=0 → no stall.
- Multi-cycle RAW, MD_LAT=4: mult to r8 issued at edge 0; decode reads r8 from cycle 1 → mdBusy high cycles 1–4, mdWb in cycle 4, issue in cycle 5, stallCnt=4.
- Structural and WAW: a second mult in cycle 2 → stalls until cycle 5. An addi writing r8 → stalls. An addi writing r9 → issues immediately.
- Boundaries:
  - A multi-cycle op with dDest=0 followed by a reader of r0 → no stall.
  - A flush on the mult cycle → mdBusy stays 0.
  - stallCnt with CNT_W=3 saturates at 7.
  - cntClr together with a stall → stallCnt=0.
- Reset mid-operation: drop resetn in cycle 2 of an outstanding mult → mdBusy=0 and stallCnt=0 immediately, no mdWb, and pcContinue=1 after release.
